dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single DataMemory port between the EX-stage load/store path (CPU) and an auxiliary requester (program loader / debug port, AUX).
- CPU has priority. A wait counter guarantees AUX forward progress. An AUX lock holds the port for bursts.
- Drives a stall to the pipeline whenever the CPU is denied.
- Sits between the EX stage and DataMemory, replacing the direct ABUS/BBUS/MW hookup.

Parameters:
- AW, 32, address width (matches ABUS).
- DW, 32, data width (matches BBUS / DATAOUT).
- MAX_WAIT, 4, max cycles AUX waits while the CPU keeps requesting; legal range 1..15.
- CW, 16, statistics counter width (only with ARB_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  EX stage memory access request (load or store) this cycle.
- cpu_we  in  1  1 = store (MW), 0 = load.
- cpu_addr  in  AW  address (ABUS).
- cpu_wdata  in  DW  store data (BBUS).
- cpu_rdata  out  DW  load data (mem_rdata pass-through).
- cpu_stall  out  1  hold pipeline; the CPU access did not occur this cycle.
- aux_req  in  1  AUX access request.
- aux_we  in  1  AUX write enable.
- aux_lock  in  1  keep the port on AUX across consecutive accesses.
- aux_addr  in  AW  AUX address.
- aux_wdata  in  DW  AUX write data.
- aux_gnt  out  1  AUX access performed this cycle.
- aux_rdata  out  DW  AUX read data; valid when aux_gnt && !aux_we.
- mem_addr  out  AW  to DataMemory ADDRESS.
- mem_wdata  out  DW  to DataMemory BIN.
- mem_wr  out  1  to DataMemory WR.
- mem_rdata  in  DW  from DataMemory DATAOUT (combinational read).

Behaviour:
- State register `owner` ∈ {OWN_CPU, OWN_AUX}; 4-bit `wait_cnt`. Reset: owner=OWN_CPU, wait_cnt=0.
- Output gating by reset: while reset is high, mem_wr=0, aux_gnt=0, cpu_stall=0.
- Access path is combinational from the registered owner. Accesses complete in the same cycle (zero latency, DataMemory reads combinationally).
- OWN_CPU:
  - mem_* = cpu_*; mem_wr = cpu_req & cpu_we.
  - cpu_stall=0; aux_gnt=0.
  - aux_req & cpu_req: wait_cnt increments, saturating at 15.
  - !aux_req: wait_cnt cleared.
  - Next state is OWN_AUX when aux_req & (!cpu_req | wait_cnt >= MAX_WAIT-1). A CPU access in the switching cycle is still performed.
- OWN_AUX:
  - mem_* = aux_*; mem_wr = aux_req & aux_we.
  - aux_gnt = aux_req; cpu_stall = cpu_req.
  - wait_cnt held at 0.
  - Next state is OWN_CPU when !aux_req, or when cpu_req & !aux_lock. Otherwise remain in OWN_AUX.
- Switch turnaround: an unlocked AUX request competing with the CPU gets exactly one access per grant. The CPU loses exactly one cycle per AUX access (no dead cycles).
- Idle: !cpu_req & !aux_req in OWN_AUX returns to OWN_CPU. The idle port drives cpu_* with mem_wr=0.
- Rdata: cpu_rdata and aux_rdata are both wired to mem_rdata. Consumers qualify with their own grant/stall.
- Starvation bounds:
  - AUX waits at most MAX_WAIT cycles under continuous cpu_req.
  - A locked AUX burst may stall the CPU indefinitely; this is by design (loader use).
- Reset mid-operation: an in-flight AUX burst is dropped. No write occurs while reset is asserted. After deassert, the block is in OWN_CPU and AUX must re-request.

Optional Feature:
- Macro: ARB_STATS_EN.
- With it defined:
  - Adds outputs stall_cnt[CW-1:0] and aux_cnt[CW-1:0], both cleared by reset.
  - stall_cnt increments each cycle cpu_stall=1.
  - aux_cnt increments each cycle aux_gnt=1.
  - Both saturate at all-ones.
- Without it: the ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF; then a load from 0x10 -> mem_wr=1 for 1 cycle, cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- AUX on idle CPU: aux_req=1, aux_we=1, addr 0x20, wdata 0x5 -> aux_gnt=1 in the 2nd cycle (after the owner switch), mem_addr=0x20, mem_wr=1.
- Starvation, MAX_WAIT=4: cpu_req held 1, aux_req asserted at cycle 0 -> owner switches after 4 cycles, aux_gnt=1 with cpu_stall=1 for 1 cycle, then back to CPU.
- Locked burst: aux_lock=1, 3 AUX writes while cpu_req=1 -> aux_gnt=1 for 3 consecutive cycles, cpu_stall=1 for those 3 cycles, CPU resumes the cycle after aux_req drops.
- Reset mid-burst: assert reset during an OWN_AUX write -> mem_wr=0 immediately, aux_gnt=0; after release owner=OWN_CPU, wait_cnt=0.
- ARB_STATS_EN: repeat the locked-burst scenario -> stall_cnt=3, aux_cnt=3; force CW=2 and run 5 stalls -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between the EX-stage
// load/store path (CPU) and an auxiliary requester (loader / debug, AUX).
// The CPU has priority. A wait counter bounds how long AUX can be held off,
// and aux_lock keeps the port on AUX for bursts. Accesses are zero latency:
// the memory port is steered combinationally from the registered owner.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
`ifdef ARB_STATS_EN
    ,
    parameter int CW       = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic          aux_lock,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic [DW-1:0] aux_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] aux_cnt
`endif
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } owner_t;

    // Once the CPU has held AUX off for MAX_WAIT-1 counted cycles, the
    // cycle with the count at this limit hands the port over.
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT - 1);

    owner_t        r_owner;
    owner_t        w_ownerNext;
    logic [3:0]    r_waitCnt;
    logic [3:0]    w_waitNext;
    logic [AW-1:0] w_memAddr;
    logic [DW-1:0] w_memWdata;
    logic          w_memWr;
    logic          w_auxGnt;
    logic          w_cpuStall;

    // Owner and wait counter registers; reset drops any AUX burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner   <= OWN_CPU;
            r_waitCnt <= 4'd0;
        end else begin
            r_owner   <= w_ownerNext;
            r_waitCnt <= w_waitNext;
        end
    end

    // Port steering, grant/stall generation and ownership hand-over.
    always_comb begin
        w_ownerNext = r_owner;
        w_waitNext  = r_waitCnt;
        w_memAddr   = cpu_addr;
        w_memWdata  = cpu_wdata;
        w_memWr     = cpu_req & cpu_we;
        w_auxGnt    = 1'b0;
        w_cpuStall  = 1'b0;
        case (r_owner)
            OWN_CPU: begin
                if (aux_req && (!cpu_req || (r_waitCnt >= WAIT_LIM))) begin
                    w_ownerNext = OWN_AUX;
                    w_waitNext  = 4'd0;
                end else if (aux_req && cpu_req) begin
                    w_waitNext = (r_waitCnt == 4'hF) ? 4'hF : r_waitCnt + 4'd1;
                end else begin
                    w_waitNext = 4'd0;
                end
            end
            OWN_AUX: begin
                w_memAddr  = aux_addr;
                w_memWdata = aux_wdata;
                w_memWr    = aux_req & aux_we;
                w_auxGnt   = aux_req;
                w_cpuStall = cpu_req;
                w_waitNext = 4'd0;
                if (!aux_req || (cpu_req && !aux_lock)) begin
                    w_ownerNext = OWN_CPU;
                end
            end
            default: begin
                w_ownerNext = OWN_CPU;
                w_waitNext  = 4'd0;
            end
        endcase
    end

    // Write, grant and stall are forced low while reset is held so nothing
    // reaches memory or the pipeline during reset.
    assign mem_addr  = w_memAddr;
    assign mem_wdata = w_memWdata;
    assign mem_wr    = w_memWr & ~reset;
    assign aux_gnt   = w_auxGnt & ~reset;
    assign cpu_stall = w_cpuStall & ~reset;
    assign cpu_rdata = mem_rdata;
    assign aux_rdata = mem_rdata;

`ifdef ARB_STATS_EN
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_stallCnt;
    logic [CW-1:0] r_auxCnt;

    // Saturating counts of CPU stall cycles and AUX grant cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_auxCnt   <= '0;
        end else begin
            if (cpu_stall && !(&r_stallCnt)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (aux_gnt && !(&r_auxCnt)) begin
                r_auxCnt <= r_auxCnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign aux_cnt   = r_auxCnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter with hand-computed
// expectations. A small behavioural DataMemory (combinational read, write on
// the rising edge) sits on the mem_* port. With ARB_STATS_EN a second
// instance with 2-bit counters shows counter saturation.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          aux_req;
    logic          aux_we;
    logic          aux_lock;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt;
    logic [DW-1:0] aux_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    int vectorCount = 0;
    int missCount   = 0;

    logic [DW-1:0] memArr [0:255];

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_lock  (aux_lock),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_gnt   (aux_gnt),
        .aux_rdata (aux_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .aux_cnt   (aux_cnt)
`endif
    );

`ifdef ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   aux_cnt;
    logic [DW-1:0] satCpuRdata;
    logic          satCpuStall;
    logic          satAuxGnt;
    logic [DW-1:0] satAuxRdata;
    logic [AW-1:0] satMemAddr;
    logic [DW-1:0] satMemWdata;
    logic          satMemWr;
    logic [1:0]    satStallCnt;
    logic [1:0]    satAuxCnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .CW(2)) dutSat (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (satCpuRdata),
        .cpu_stall (satCpuStall),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_lock  (aux_lock),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_gnt   (satAuxGnt),
        .aux_rdata (satAuxRdata),
        .mem_addr  (satMemAddr),
        .mem_wdata (satMemWdata),
        .mem_wr    (satMemWr),
        .mem_rdata (mem_rdata),
        .stall_cnt (satStallCnt),
        .aux_cnt   (satAuxCnt)
    );
`endif

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DataMemory: combinational read, write on the rising edge.
    assign mem_rdata = memArr[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_wr) memArr[mem_addr[7:0]] <= mem_wdata;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives every requester input for one cycle, then lets the
    // combinational paths settle before checks are made.
    task automatic applyStimulus(input logic cr, input logic cwe,
                                 input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                                 input logic ar, input logic awe, input logic alk,
                                 input logic [AW-1:0] aaddr, input logic [DW-1:0] awd);
        cpu_req   = cr;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        aux_req   = ar;
        aux_we    = awe;
        aux_lock  = alk;
        aux_addr  = aaddr;
        aux_wdata = awd;
        #2;
    endtask

    // Advances to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = '0;

        // Reset held with both requesters asking to write: all gated off.
        reset = 1'b1;
        applyStimulus(1, 1, 32'h10, 32'h1111, 1, 1, 1, 32'h20, 32'h2222);
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_aux_gnt", aux_gnt, 0);
        checkOutput("rst_cpu_stall", cpu_stall, 0);
        nextCycle();
        nextCycle();
        reset = 1'b0;

        // CPU store then load at 0x10.
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("cpu_st_wr", mem_wr, 1);
        checkOutput("cpu_st_addr", mem_addr, 32'h10);
        checkOutput("cpu_st_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("cpu_st_stall", cpu_stall, 0);
        checkOutput("cpu_st_gnt", aux_gnt, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("cpu_ld_wr", mem_wr, 0);
        checkOutput("cpu_ld_rdata", cpu_rdata, 32'hDEADBEEF);
        checkOutput("cpu_ld_stall", cpu_stall, 0);
        nextCycle();

        // AUX write on an idle CPU: granted in the second cycle.
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 0, 32'h20, 32'h5);
        checkOutput("aux_idle_c1_gnt", aux_gnt, 0);
        checkOutput("aux_idle_c1_wr", mem_wr, 0);
        nextCycle();
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 0, 32'h20, 32'h5);
        checkOutput("aux_idle_c2_gnt", aux_gnt, 1);
        checkOutput("aux_idle_c2_addr", mem_addr, 32'h20);
        checkOutput("aux_idle_c2_wr", mem_wr, 1);
        checkOutput("aux_idle_c2_wdata", mem_wdata, 32'h5);
        checkOutput("aux_idle_c2_stall", cpu_stall, 0);
        nextCycle();
        applyStimulus(0, 0, 32'h20, 32'h0, 0, 0, 0, 32'h20, 32'h5);
        checkOutput("aux_idle_drop_gnt", aux_gnt, 0);
        checkOutput("aux_idle_drop_wr", mem_wr, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("aux_data_rdback", cpu_rdata, 32'h5);
        checkOutput("aux_data_stall", cpu_stall, 0);
        nextCycle();

        // Starvation bound: CPU loads every cycle, AUX read waits 4 cycles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
            checkOutput($sformatf("starve_w%0d_gnt", i), aux_gnt, 0);
            checkOutput($sformatf("starve_w%0d_stall", i), cpu_stall, 0);
            checkOutput($sformatf("starve_w%0d_addr", i), mem_addr, 32'h10);
            nextCycle();
        end
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        checkOutput("starve_g_gnt", aux_gnt, 1);
        checkOutput("starve_g_stall", cpu_stall, 1);
        checkOutput("starve_g_addr", mem_addr, 32'h20);
        checkOutput("starve_g_rdata", aux_rdata, 32'h5);
        checkOutput("starve_g_wr", mem_wr, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        checkOutput("starve_back_gnt", aux_gnt, 0);
        checkOutput("starve_back_stall", cpu_stall, 0);
        checkOutput("starve_back_rdata", cpu_rdata, 32'hDEADBEEF);
        nextCycle();

        // Clean reset so the burst starts from cleared counters.
        reset = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        nextCycle();
        reset = 1'b0;

        // Locked burst of three AUX writes against a requesting CPU.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 1, 1, 32'h30, 32'h1);
            checkOutput($sformatf("burst_w%0d_gnt", i), aux_gnt, 0);
            checkOutput($sformatf("burst_w%0d_wr", i), mem_wr, 0);
            nextCycle();
        end
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 1, 1, 32'h30 + 32'(g), 32'h1 + 32'(g));
            checkOutput($sformatf("burst_g%0d_gnt", g), aux_gnt, 1);
            checkOutput($sformatf("burst_g%0d_stall", g), cpu_stall, 1);
            checkOutput($sformatf("burst_g%0d_wr", g), mem_wr, 1);
            checkOutput($sformatf("burst_g%0d_addr", g), mem_addr, 32'h30 + 32'(g));
            nextCycle();
        end
        applyStimulus(1, 0, 32'h31, 32'h0, 0, 0, 1, 32'h0, 32'h0);
        checkOutput("burst_drop_gnt", aux_gnt, 0);
        checkOutput("burst_drop_stall", cpu_stall, 1);
        checkOutput("burst_drop_wr", mem_wr, 0);
`ifdef ARB_STATS_EN
        checkOutput("stats_stall_3", stall_cnt, 3);
        checkOutput("stats_aux_3", aux_cnt, 3);
        checkOutput("sat_stall_3", satStallCnt, 3);
        checkOutput("sat_aux_3", satAuxCnt, 3);
`endif
        nextCycle();
        applyStimulus(1, 0, 32'h31, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("burst_resume_stall", cpu_stall, 0);
        checkOutput("burst_resume_rdata", cpu_rdata, 32'h2);
`ifdef ARB_STATS_EN
        checkOutput("stats_stall_4", stall_cnt, 4);
        checkOutput("stats_aux_hold", aux_cnt, 3);
        checkOutput("sat_stall_sat", satStallCnt, 3);
`endif
        nextCycle();

        // Reset asserted in the middle of a locked AUX write burst.
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h40, 32'h77);
        checkOutput("mid_c0_gnt", aux_gnt, 0);
        nextCycle();
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h40, 32'h77);
        checkOutput("mid_c1_gnt", aux_gnt, 1);
        checkOutput("mid_c1_wr", mem_wr, 1);
        checkOutput("mid_c1_addr", mem_addr, 32'h40);
        nextCycle();
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h40, 32'h88);
        checkOutput("mid_c2_gnt", aux_gnt, 1);
        checkOutput("mid_c2_wr", mem_wr, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_wr", mem_wr, 0);
        checkOutput("mid_rst_gnt", aux_gnt, 0);
        checkOutput("mid_rst_stall", cpu_stall, 0);
`ifdef ARB_STATS_EN
        checkOutput("mid_rst_stats", stall_cnt, 0);
`endif
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h40, 32'h88);
        checkOutput("post_rst_gnt", aux_gnt, 0);
        checkOutput("post_rst_wr", mem_wr, 0);
        checkOutput("post_rst_addr", mem_addr, 32'h10);
        nextCycle();
        applyStimulus(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("post_rst_aux_stall", cpu_stall, 1);
        checkOutput("post_rst_aux_gnt", aux_gnt, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("post_rst_cpu_stall", cpu_stall, 0);
        checkOutput("post_rst_no_write", cpu_rdata, 32'h77);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
